ahb_lite_uart_master: RTL and testbench

//  Byte-stream-to-AHB-Lite initiator: parses debug commands from a UART RX byte stream and

---
 rtl/ahb_lite_uart_master_if.sv | 50 +++++
 rtl/ahb_lite_uart_master.sv | 193 +++++++++++++++++++
 tb/tb_ahb_lite_uart_master.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_uart_master_if.sv
//------------------------------------------------------------------------------
// Module   : ahb_lite_uart_master_if
// Purpose  : AHB-Lite master port plus UART byte-stream handshakes for the bridge
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface ahb_lite_uart_master_if #(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32
) ();
  logic [HADDR_WIDTH-1:0] HADDR;
  logic [1:0]             HTRANS;
  logic [2:0]             HSIZE;
  logic [2:0]             HBURST;
  logic [3:0]             HPROT;
  logic                   HMASTLOCK;
  logic                   HWRITE;
  logic [HDATA_WIDTH-1:0] HWDATA;
  logic [HDATA_WIDTH-1:0] HRDATA;
  logic                   HREADY;
  logic                   HRESP;
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP,
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP,
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_valid,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/ahb_lite_uart_master.sv
//------------------------------------------------------------------------------
// Module   : ahb_lite_uart_master
// Purpose  : Parses UART debug commands into single-byte AHB-Lite transfers.
//            Optional macro AHB_UART_MASTER_AUTOINC_EN adds 'w'/'r' auto-increment.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ahb_lite_uart_master #(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32
) (
  input  wire logic              HCLK,
  input  wire logic              HRESETn,
  ahb_lite_uart_master_if.master io_bus
);

  localparam logic [2:0] S_OPC  = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_APH  = 3'd3;
  localparam logic [2:0] S_DPH  = 3'd4;
  localparam logic [2:0] S_RSP1 = 3'd5;
  localparam logic [2:0] S_RSP2 = 3'd6;

  localparam logic [7:0] C_OP_W  = 8'h57;
  localparam logic [7:0] C_OP_R  = 8'h52;
  localparam logic [7:0] C_RSP_K = 8'h4B;
  localparam logic [7:0] C_RSP_E = 8'h45;
  localparam logic [7:0] C_RSP_Q = 8'h3F;
`ifdef AHB_UART_MASTER_AUTOINC_EN
  localparam logic [7:0] C_OP_WI = 8'h77;
  localparam logic [7:0] C_OP_RI = 8'h72;
`endif

  logic [2:0]  r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_write;
  logic        r_rsp2;
  logic        w_in_ready;
  logic        w_in_fire;
  logic        w_out_fire;
  logic [7:0]  w_lane;

  generate
    if (HDATA_WIDTH == 8) begin : g_lane8
      assign w_lane = io_bus.HRDATA[7:0];
    end else begin : g_lane32
      assign w_lane = io_bus.HRDATA[{r_addr[1:0], 3'b000} +: 8];
    end
  endgenerate

`ifdef AHB_UART_MASTER_AUTOINC_EN
  logic [HADDR_WIDTH-1:0] r_last_addr;
  logic [HADDR_WIDTH-1:0] w_auto_addr;
  assign w_auto_addr = r_last_addr + HADDR_WIDTH'(1);
`endif

  assign w_in_ready = (r_state == S_OPC) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_in_fire  = io_bus.in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & io_bus.out_ready;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_OPC;
      r_cnt       <= 2'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 8'd0;
      r_rdata     <= 8'd0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_write     <= 1'b0;
      r_rsp2      <= 1'b0;
`ifdef AHB_UART_MASTER_AUTOINC_EN
      r_last_addr <= '0;
`endif
    end else begin
      case (r_state)
        S_OPC: begin
          if (w_in_fire) begin
            r_cnt <= 2'd0;
            case (io_bus.in_data)
              C_OP_W: begin
                r_write <= 1'b1;
                r_rsp2  <= 1'b0;
                r_state <= S_ADDR;
              end
              C_OP_R: begin
                r_write <= 1'b0;
                r_rsp2  <= 1'b1;
                r_state <= S_ADDR;
              end
`ifdef AHB_UART_MASTER_AUTOINC_EN
              C_OP_WI: begin
                r_write <= 1'b1;
                r_rsp2  <= 1'b0;
                r_addr  <= 32'(w_auto_addr);
                r_state <= S_DATA;
              end
              C_OP_RI: begin
                r_write <= 1'b0;
                r_rsp2  <= 1'b1;
                r_addr  <= 32'(w_auto_addr);
                r_state <= S_APH;
              end
`endif
              default: begin
                r_rsp2      <= 1'b0;
                r_out_data  <= C_RSP_Q;
                r_out_valid <= 1'b1;
                r_state     <= S_RSP1;
              end
            endcase
          end
        end
        S_ADDR: begin
          // Four shifts fully replace the 32-bit register, so no clear is needed.
          if (w_in_fire) begin
            r_addr <= {r_addr[23:0], io_bus.in_data};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= r_write ? S_DATA : S_APH;
            end
          end
        end
        S_DATA: begin
          if (w_in_fire) begin
            r_wdata <= io_bus.in_data;
            r_state <= S_APH;
          end
        end
        S_APH: begin
          if (io_bus.HREADY) begin
            r_state <= S_DPH;
          end
        end
        S_DPH: begin
          // An ERROR's first cycle (HREADY=0) is just waited out; status is taken here.
          if (io_bus.HREADY) begin
            r_rdata     <= io_bus.HRESP ? 8'd0 : w_lane;
            r_out_data  <= io_bus.HRESP ? C_RSP_E : C_RSP_K;
            r_out_valid <= 1'b1;
            r_state     <= S_RSP1;
`ifdef AHB_UART_MASTER_AUTOINC_EN
            if (!io_bus.HRESP) begin
              r_last_addr <= r_addr[HADDR_WIDTH-1:0];
            end
`endif
          end
        end
        S_RSP1: begin
          if (w_out_fire) begin
            if (r_rsp2) begin
              r_out_data <= r_rdata;
              r_state    <= S_RSP2;
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= S_OPC;
            end
          end
        end
        S_RSP2: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_state     <= S_OPC;
          end
        end
        default: r_state <= S_OPC;
      endcase
    end
  end

  assign io_bus.HADDR     = r_addr[HADDR_WIDTH-1:0];
  assign io_bus.HTRANS    = (r_state == S_APH) ? 2'b10 : 2'b00;
  assign io_bus.HSIZE     = 3'b000;
  assign io_bus.HBURST    = 3'b000;
  assign io_bus.HPROT     = 4'b0011;
  assign io_bus.HMASTLOCK = 1'b0;
  assign io_bus.HWRITE    = r_write;
  assign io_bus.HWDATA    = {(HDATA_WIDTH/8){r_wdata}};
  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_uart_master.sv
//------------------------------------------------------------------------------
// Module   : tb_ahb_lite_uart_master
// Purpose  : Scoreboard bench for ahb_lite_uart_master (AHB_UART_MASTER_AUTOINC_EN aware)
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ahb_lite_uart_master;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_lite_uart_master_if #(.HADDR_WIDTH(32), .HDATA_WIDTH(32)) bus ();

  ahb_lite_uart_master #(.HADDR_WIDTH(32), .HDATA_WIDTH(32)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .io_bus  (bus.master)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [7:0]  out_q[$];
  int          tests = 0;
  int          fails = 0;
  int          g_wait = 0;
  logic        g_err = 1'b0;
  logic [31:0] g_rdata = 32'd0;
  int          s_ph = 0;
  int          s_cnt = 0;
  logic        wd_pend = 1'b0;
  logic [31:0] wd_exp = 32'd0;
  logic [7:0]  mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic w, input logic [31:0] d);
    bus_t e;
    e.addr = a; e.wr = w; e.wdata = d;
    bus_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge HCLK);
    while (!bus.in_ready && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    if (!bus.in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for byte 0x%h", b);
    end
    @(posedge HCLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_addr(input logic [7:0] op, input logic [31:0] a);
    send(op);
    send(a[31:24]); send(a[23:16]); send(a[15:8]); send(a[7:0]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((out_q.size() != 0 || bus_q.size() != 0) && n < 300) begin
      @(negedge HCLK);
      n++;
    end
    chk("drain_pending", 32'(out_q.size() + bus_q.size()), 32'd0);
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  // Zero-wait by default; g_wait stretches the address phase, g_err gives a two-cycle ERROR.
  initial begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'd0;
    forever begin
      @(posedge HCLK);
      #1;
      if (!HRESETn) begin
        s_ph = 0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end else begin
        case (s_ph)
          0: if (bus.HTRANS == 2'b10) begin
               if (g_wait > 0) begin bus.HREADY = 1'b0; s_cnt = g_wait; s_ph = 1; end
               else s_ph = 2;
             end
          1: begin
               s_cnt--;
               if (s_cnt == 0) begin bus.HREADY = 1'b1; s_ph = 2; end
             end
          2: begin
               bus.HRDATA = g_rdata;
               if (g_err) begin bus.HREADY = 1'b0; bus.HRESP = 1'b1; s_ph = 3; end
               else begin bus.HREADY = 1'b1; bus.HRESP = 1'b0; s_ph = 4; end
             end
          3: begin bus.HREADY = 1'b1; s_ph = 4; end
          default: begin bus.HREADY = 1'b1; bus.HRESP = 1'b0; s_ph = 0; end
        endcase
      end
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn && bus.out_valid && bus.out_ready) begin
      if (out_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL out_unexpected: got 0x%h expected no byte", bus.out_data);
      end else begin
        mon_e = out_q.pop_front();
        chk("out_byte", 32'(bus.out_data), 32'(mon_e));
      end
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (wd_pend) begin
        chk("dph_hwdata", bus.HWDATA, wd_exp);
        chk("dph_htrans", 32'(bus.HTRANS), 32'd0);
        wd_pend = 1'b0;
      end
      if (bus.HTRANS == 2'b10) begin
        if (bus_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL bus_unexpected: got NONSEQ at 0x%h expected none", bus.HADDR);
        end else begin
          chk("aph_haddr", bus.HADDR, bus_q[0].addr);
          chk("aph_hwrite", 32'(bus.HWRITE), 32'(bus_q[0].wr));
          chk("aph_ctrl", 32'({bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK}), 32'({3'b000, 3'b000, 4'b0011, 1'b0}));
          if (bus.HREADY) begin
            if (bus_q[0].wr) begin wd_pend = 1'b1; wd_exp = bus_q[0].wdata; end
            void'(bus_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data   = 8'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2 HRESETn = 1'b0;
    #2;
    chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
    chk("rst_haddr", bus.HADDR, 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Zero-wait write with latency check.
    exp_bus(32'h10, 1'b1, 32'hA5A5A5A5);
    out_q.push_back(8'h4B);
    send_addr(8'h57, 32'h0000_0010);
    send(8'hA5);
    @(negedge HCLK); chk("lat_c1_htrans", 32'(bus.HTRANS), 32'd2);
    @(negedge HCLK); chk("lat_c2_valid", 32'(bus.out_valid), 32'd0);
    @(negedge HCLK); chk("lat_c3_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_c3_data", 32'(bus.out_data), 32'h4B);
    wait_drain();

    // Read from lane 3.
    g_rdata = 32'h5A00_0000;
    exp_bus(32'h13, 1'b0, 32'd0);
    out_q.push_back(8'h4B); out_q.push_back(8'h5A);
    send_addr(8'h52, 32'h0000_0013);
    wait_drain();

    // Address phase stretched by 3 waits, then ERROR.
    g_wait = 3; g_err = 1'b1; g_rdata = 32'hFFFF_FFFF;
    exp_bus(32'h20, 1'b0, 32'd0);
    out_q.push_back(8'h45); out_q.push_back(8'h00);
    send_addr(8'h52, 32'h0000_0020);
    wait_drain();
    g_wait = 0; g_err = 1'b0;

    // Unknown opcode under back-pressure, then a write.
    bus.out_ready = 1'b0;
    out_q.push_back(8'h3F);
    send(8'h00);
    repeat (5) begin
      @(negedge HCLK);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data", 32'(bus.out_data), 32'h3F);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge HCLK); #1 bus.out_ready = 1'b1;
    exp_bus(32'h44, 1'b1, 32'h7777_7777);
    out_q.push_back(8'h4B);
    send_addr(8'h57, 32'h0000_0044);
    send(8'h77);
    wait_drain();

    // Reset in the middle of a command.
    send(8'h57); send(8'h00); send(8'h00);
    #2 HRESETn = 1'b0;
    #1;
    chk("mid_rst_htrans", 32'(bus.HTRANS), 32'd0);
    chk("mid_rst_haddr", bus.HADDR, 32'd0);
    chk("mid_rst_hwrite", 32'(bus.HWRITE), 32'd0);
    chk("mid_rst_hwdata", bus.HWDATA, 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    g_rdata = 32'h0000_CC00;
    exp_bus(32'h09, 1'b0, 32'd0);
    out_q.push_back(8'h4B); out_q.push_back(8'hCC);
    send_addr(8'h52, 32'h0000_0009);
    wait_drain();

`ifdef AHB_UART_MASTER_AUTOINC_EN
    exp_bus(32'hFF, 1'b1, 32'h1111_1111);
    out_q.push_back(8'h4B);
    send_addr(8'h57, 32'h0000_00FF);
    send(8'h11);
    wait_drain();
    exp_bus(32'h100, 1'b1, 32'h2222_2222);
    out_q.push_back(8'h4B);
    send(8'h77); send(8'h22);
    wait_drain();
    g_rdata = 32'h0000_3300;
    exp_bus(32'h101, 1'b0, 32'd0);
    out_q.push_back(8'h4B); out_q.push_back(8'h33);
    send(8'h72);
    wait_drain();
`else
    out_q.push_back(8'h3F);
    send(8'h77);
    wait_drain();
    out_q.push_back(8'h3F);
    send(8'h72);
    wait_drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
